// File: rtl/baud_gen_frac.sv
// Fractional-N baud generator: os_tick / mid_tick / baud_tick from sys_clk.
// Define BAUD_GEN_FRAC_EN to enable the fractional accumulator; otherwise P = max(div_int,2).
module baud_gen_frac #(
  parameter int DIV_W      = 16,
  parameter int FRAC_W     = 4,
  parameter int OVERSAMPLE = 16,
  parameter int DEF_INT    = 13,
  parameter int DEF_FRAC   = 9
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic              en,
  input  logic              sync,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              div_load,
  output logic              div_ack,
  output logic              os_tick,
  output logic              mid_tick,
  output logic              baud_tick
);
  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam int P_W  = DIV_W + 1;
  typedef logic [P_W-1:0] plen_t;
  localparam plen_t P_RST = plen_t'((DEF_INT < 2) ? 2 : DEF_INT);

  function automatic plen_t eff_int(input logic [DIV_W-1:0] d);
    return (d < DIV_W'(2)) ? plen_t'(2) : plen_t'(d);
  endfunction

  logic [DIV_W-1:0] act_int, shd_int, nxt_int;
  plen_t            cnt, p_len, p_nxt;
  logic [OS_W-1:0]  os_cnt;
  logic             pending, tick, load_now, apply_shd, restart;

  // sync always wins over a period end that lands on the same edge
  assign tick      = en && !sync && (cnt == p_len - plen_t'(1));
  assign load_now  = sync && div_load;
  assign apply_shd = pending && !load_now && (sync || !en || tick);
  assign nxt_int   = load_now ? div_int : (apply_shd ? shd_int : act_int);
  assign restart   = sync || tick;

`ifdef BAUD_GEN_FRAC_EN
  logic [FRAC_W-1:0] act_frac, shd_frac, nxt_frac, acc, acc_nxt;
  logic [FRAC_W:0]   sum;

  // carry for the new period is the overflow of the add done at its end
  assign acc_nxt  = sync ? '0 : (tick ? acc + act_frac : acc);
  assign nxt_frac = load_now ? div_frac : (apply_shd ? shd_frac : act_frac);
  assign sum      = {1'b0, acc_nxt} + {1'b0, nxt_frac};
  assign p_nxt    = eff_int(nxt_int) + plen_t'(sum[FRAC_W]);

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      acc      <= '0;
      act_frac <= FRAC_W'(DEF_FRAC);
      shd_frac <= FRAC_W'(DEF_FRAC);
    end else begin
      acc      <= acc_nxt;
      act_frac <= nxt_frac;
      if (div_load && !load_now) shd_frac <= div_frac;
    end
  end
`else
  logic unused_frac;
  assign unused_frac = ^{div_frac, FRAC_W'(DEF_FRAC)};
  assign p_nxt       = eff_int(nxt_int);
`endif

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      os_cnt    <= '0;
      p_len     <= P_RST;
      act_int   <= DIV_W'(DEF_INT);
      shd_int   <= DIV_W'(DEF_INT);
      pending   <= 1'b0;
      div_ack   <= 1'b0;
      os_tick   <= 1'b0;
      mid_tick  <= 1'b0;
      baud_tick <= 1'b0;
    end else begin
      act_int <= nxt_int;
      if (div_load && !load_now) shd_int <= div_int;
      pending <= !load_now && (div_load || (pending && !apply_shd));
      // period length is latched only when a new period begins
      if (restart) p_len <= p_nxt;
      if (sync)    cnt <= '0;
      else if (en) cnt <= tick ? '0 : cnt + plen_t'(1);
      if (sync)      os_cnt <= '0;
      else if (tick) os_cnt <= os_cnt + OS_W'(1);
      os_tick   <= tick;
      mid_tick  <= tick && (os_cnt == OS_W'(OVERSAMPLE/2 - 1));
      baud_tick <= tick && (os_cnt == OS_W'(OVERSAMPLE - 1));
      div_ack   <= load_now || apply_shd;
    end
  end
endmodule

// File: doc/baud_gen_frac.md
Name: baud_gen_frac

Overview:
- Parametrised successor to the fixed-rate baud generator: fractional-N divider producing an oversample tick, a mid-bit sample tick and a bit-rate tick from sys_clk.
- Divisor is runtime-programmable with a glitch-free load handshake; phase can be re-aligned by the UART receiver on start-bit detection.
- Feeds uart_rx (os_tick, mid_tick) and uart_tx (baud_tick) in the pattern-matching datapath.

Parameters:
- DIV_W, 16, width of integer divisor.
- FRAC_W, 4, width of fractional divisor; step is 1/2^FRAC_W.
- OVERSAMPLE, 16, os_ticks per bit; power of two, >= 4.
- DEF_INT, 13, integer divisor after reset (25 MHz, 115200 baud x16).
- DEF_FRAC, 9, fractional divisor after reset.

Ports:
- sys_clk  in  1  system clock (25 MHz nominal)
- reset  in  1  asynchronous, active-low reset
- en  in  1  run enable; 0 freezes all counters
- sync  in  1  one-cycle pulse; restarts bit phase
- div_int  in  DIV_W  requested integer divisor
- div_frac  in  FRAC_W  requested fractional divisor
- div_load  in  1  one-cycle pulse; capture div_int/div_frac
- div_ack  out  1  one-cycle pulse; new divisor now active
- os_tick  out  1  oversample tick, one cycle wide
- mid_tick  out  1  tick at the middle of each bit
- baud_tick  out  1  tick at the end of each bit

Behaviour:
- Reset (reset=0, async): cnt=0, os_cnt=0, frac_acc=0, active divisor = DEF_INT/DEF_FRAC, pending flag=0. All outputs 0.
- All outputs are registered, high for exactly one sys_clk cycle.
- Period length: P = max(div_int_active, 2) + carry, with carry = (frac_acc + div_frac_active) >= 2^FRAC_W. P is evaluated at the start of each period.
- At each os_tick, frac_acc <= (frac_acc + div_frac_active) mod 2^FRAC_W.
- Average period is div_int + div_frac/2^FRAC_W cycles.
- With en=1, cnt counts 0..P-1. os_tick is asserted in the cycle after cnt==P-1, so the first os_tick follows the P-th enabled edge after reset release.
- os_cnt increments on each os_tick, mod OVERSAMPLE.
- mid_tick = os_tick on which os_cnt goes OVERSAMPLE/2-1 -> OVERSAMPLE/2 (the 8th tick).
- baud_tick = os_tick on which os_cnt wraps OVERSAMPLE-1 -> 0 (the 16th tick).
- en=0: cnt, os_cnt and frac_acc hold; no ticks. Counting resumes from the held state when en returns to 1.
- div_load: captures inputs into a shadow register and sets pending.
  - If pending and en=1, the shadow becomes active at the next period boundary (the cycle os_tick is issued); div_ack pulses that same cycle.
  - If en=0, the shadow is applied on the next cycle, with div_ack.
  - A second div_load while pending overwrites the shadow; only one div_ack is issued.
- sync: next cycle cnt=0, os_cnt=0, frac_acc=0; no tick that cycle. A pending divisor is applied, with div_ack.
  - sync outranks a coincident period end: that tick is suppressed.
  - sync and div_load in the same cycle: the new inputs are applied immediately, with div_ack.
- div_int < 2 is treated as 2.
- div_int changes without div_load are ignored.

Optional Feature:
- BAUD_GEN_FRAC_EN defined: fractional accumulator as above.
- BAUD_GEN_FRAC_EN undefined: frac_acc and carry are removed, div_frac and DEF_FRAC are ignored, and P = max(div_int, 2) exactly. Port list is unchanged.

Test Plan:
- Reset release, default divisor, macro on -> os_tick periods follow the 13/14 pattern: 16 os_ticks in 217 cycles, baud_tick at the 16th os_tick, mid_tick at the 8th.
- div_load with int=4, frac=0 -> div_ack at the next boundary; os_tick every 4 cycles; baud_tick every 64 cycles.
- int=4, frac=8 -> periods 4,5,4,5...; 16 os_ticks = 72 cycles. Macro off: 64 cycles.
- sync pulse 2 cycles before an expected os_tick -> that tick suppressed; next os_tick P cycles after sync+1; mid_tick 8 os_ticks later.
- en low for 20 cycles mid-period -> no ticks; the remaining period completes after en returns.
- reset asserted mid-count, div_int=0 loaded afterwards -> outputs drop to 0 asynchronously; then os_tick every 2 cycles.
